// File: rtl/knn_kbest_sel_pkg.sv
// Shared definitions for the K-best neighbour selector: FSM states and
// sizing helpers for the packed table entry {valid, dist, label}.
package knn_kbest_sel_pkg;

    typedef enum logic {
        KB_COLLECT = 1'b0,
        KB_DRAIN   = 1'b1
    } kb_state_e;

    // Packed entry layout, MSB first: valid, dist[DATA_W], label[LABEL_W].
    function automatic int kb_entry_w(input int data_w, input int label_w);
        return 1 + data_w + label_w;
    endfunction

    function automatic int kb_idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/knn_kbest_sel_cell.sv
// One slot of the sorted K-best table. Takes the new entry when it is the
// first slot that beats it, or shifts in its lower neighbour when a lower slot did.
module knn_kbest_sel_cell
    import knn_kbest_sel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8,
    parameter int ENTRY_W = kb_entry_w(DATA_W, LABEL_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               ins_i,
    input  logic [DATA_W-1:0]  new_dist_i,
    input  logic [LABEL_W-1:0] new_label_i,
    input  logic [ENTRY_W-1:0] lower_entry_i,
    input  logic               lower_taken_i,
    output logic [ENTRY_W-1:0] entry_o,
    output logic               taken_o
);

    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic               slot_valid;
    logic [DATA_W-1:0]  slot_dist;
    logic               take_here;

    assign slot_valid = entry_q[ENTRY_W-1];
    assign slot_dist  = entry_q[ENTRY_W-2 -: DATA_W];

    // Strict compare keeps the earlier of two equal distances in the lower rank.
    assign take_here = !lower_taken_i && (!slot_valid || (new_dist_i < slot_dist));
    assign taken_o   = lower_taken_i | take_here;

    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = '0;
        end else if (ins_i) begin
            if (lower_taken_i) begin
                entry_d = lower_entry_i;
            end else if (take_here) begin
                entry_d = {1'b1, new_dist_i, new_label_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/knn_kbest_sel.sv
// K-best selector: keeps the K nearest (distance, label) pairs of a query in
// a sorted shift table, then streams them out nearest-first.
module knn_kbest_sel
    import knn_kbest_sel_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  LABEL_W = 8,
    parameter int  K       = 4,
    parameter int  CNT_W   = 16,
    localparam int IDX_W   = kb_idx_w(K),
    localparam int ENTRY_W = kb_entry_w(DATA_W, LABEL_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  in_dist_i,
    input  logic [LABEL_W-1:0] in_label_i,
    input  logic               in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_dist_o,
    output logic [LABEL_W-1:0] out_label_o,
    output logic [IDX_W-1:0]   out_idx_o,
    output logic               out_last_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   sample_cnt_o
);

    kb_state_e          state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     n_valid_q, n_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ENTRY_W-1:0] slot_entry [K];
    logic               slot_taken [K];
    logic [DATA_W-1:0]  slot_dist  [K];
    logic [LABEL_W-1:0] slot_label [K];

    logic               accept;
    logic               drain_fire;
    logic               last_entry;
    logic               flush;
    logic               last_slot_valid;
    logic [DATA_W-1:0]  mux_dist;
    logic [LABEL_W-1:0] mux_label;

    // A sample arriving together with clear is discarded.
    assign accept          = in_ready_q & in_valid_i & ~clear_i;
    assign drain_fire      = (state_q == KB_DRAIN) & out_ready_i;
    assign last_entry      = (state_q == KB_DRAIN) &&
                             ({1'b0, idx_q} == (n_valid_q - 1'b1));
    assign flush           = clear_i | (drain_fire & last_entry);
    assign last_slot_valid = slot_entry[K-1][ENTRY_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                knn_kbest_sel_cell #(
                    .DATA_W  (DATA_W),
                    .LABEL_W (LABEL_W),
                    .ENTRY_W (ENTRY_W)
                ) u_cell (
                    .clk_i         (clk_i),
                    .rst_ni        (rst_ni),
                    .flush_i       (flush),
                    .ins_i         (accept),
                    .new_dist_i    (in_dist_i),
                    .new_label_i   (in_label_i),
                    .lower_entry_i ({ENTRY_W{1'b0}}),
                    .lower_taken_i (1'b0),
                    .entry_o       (slot_entry[gi]),
                    .taken_o       (slot_taken[gi])
                );
            end else begin : g_chain
                knn_kbest_sel_cell #(
                    .DATA_W  (DATA_W),
                    .LABEL_W (LABEL_W),
                    .ENTRY_W (ENTRY_W)
                ) u_cell (
                    .clk_i         (clk_i),
                    .rst_ni        (rst_ni),
                    .flush_i       (flush),
                    .ins_i         (accept),
                    .new_dist_i    (in_dist_i),
                    .new_label_i   (in_label_i),
                    .lower_entry_i (slot_entry[gi-1]),
                    .lower_taken_i (slot_taken[gi-1]),
                    .entry_o       (slot_entry[gi]),
                    .taken_o       (slot_taken[gi])
                );
            end
            assign slot_dist[gi]  = slot_entry[gi][ENTRY_W-2 -: DATA_W];
            assign slot_label[gi] = slot_entry[gi][LABEL_W-1:0];
        end
    endgenerate

    always_comb begin
        mux_dist  = '0;
        mux_label = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == IDX_W'(i)) begin
                mux_dist  = slot_dist[i];
                mux_label = slot_label[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        idx_d      = idx_q;
        n_valid_d  = n_valid_q;
        cnt_d      = cnt_q;
        if (clear_i) begin
            state_d    = KB_COLLECT;
            in_ready_d = 1'b1;
            idx_d      = '0;
            n_valid_d  = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                KB_COLLECT: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        // The table only grows while its top slot is still empty.
                        if (slot_taken[K-1] && !last_slot_valid) begin
                            n_valid_d = n_valid_q + 1'b1;
                        end
                        if (in_last_i) begin
                            state_d    = KB_DRAIN;
                            in_ready_d = 1'b0;
                            idx_d      = '0;
                        end
                    end
                end
                KB_DRAIN: begin
                    in_ready_d = 1'b0;
                    if (drain_fire) begin
                        if (last_entry) begin
                            state_d    = KB_COLLECT;
                            in_ready_d = 1'b1;
                            idx_d      = '0;
                            n_valid_d  = '0;
                            cnt_d      = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = KB_COLLECT;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= KB_COLLECT;
            in_ready_q <= 1'b0;
            idx_q      <= '0;
            n_valid_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            idx_q      <= idx_d;
            n_valid_q  <= n_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = (state_q == KB_DRAIN);
    assign busy_o       = (state_q == KB_DRAIN);
    assign out_dist_o   = mux_dist;
    assign out_label_o  = mux_label;
    assign out_idx_o    = idx_q;
    assign out_last_o   = last_entry;
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_knn_kbest_sel.sv
// Directed bench for knn_kbest_sel: expected drain entries are queued as each
// query is driven and checked as the selector hands them out.
module tb_knn_kbest_sel;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dist;
    logic [7:0]  in_label;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dist;
    logic [7:0]  out_label;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic [15:0] sample_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  l;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    knn_kbest_sel #(
        .DATA_W  (32),
        .LABEL_W (8),
        .K       (4),
        .CNT_W   (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_dist_i    (in_dist),
        .in_label_i   (in_label),
        .in_last_i    (in_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_dist_o   (out_dist),
        .out_label_o  (out_label),
        .out_idx_o    (out_idx),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .sample_cnt_o (sample_cnt)
    );

    always #5 clk = ~clk;

    // Output side of the scoreboard: one line per drained entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t obs;
            exp_t e;
            obs.d    = out_dist;
            obs.l    = out_label;
            obs.idx  = out_idx;
            obs.last = out_last;
            $display("drain idx=%0d dist=%0d label=%0d last=%0d", out_idx, out_dist, out_label, out_last);
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL drain_extra observed dist=%0d label=%0d idx=%0d required no entry", out_dist, out_label, out_idx);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_assert++;
                assert (obs === e) else begin
                    n_fail++;
                    $error("FAIL drain_entry observed %0d/L%0d idx%0d last%0d required %0d/L%0d idx%0d last%0d",
                           obs.d, obs.l, obs.idx, obs.last, e.d, e.l, e.idx, e.last);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] l, input logic [1:0] idx, input logic last);
        exp_t e;
        e.d    = d;
        e.l    = l;
        e.idx  = idx;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] l, input logic last);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_dist  = d;
        in_label = l;
        in_last  = last;
        guard    = 0;
        do begin
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 50);
        $display("send dist=%0d label=%0d last=%0d", d, l, last);
        chk("send_accept", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input bit rnd);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        out_ready = 1'b1;
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_done_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_label  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset and idle
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_idx", {62'd0, out_idx}, 64'd0);
        chk("rst_out_dist", {32'd0, out_dist}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sample_cnt", {48'd0, sample_cnt}, 64'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", {63'd0, in_ready}, 64'd0);
        tick();
        chk("ready_after_edge", {63'd0, in_ready}, 64'd1);

        // Ordering, back-to-back input
        out_ready = 1'b1;
        push(32'd34, 8'd2, 2'd0, 1'b0);
        push(32'd500, 8'd4, 2'd1, 1'b0);
        push(32'd1044, 8'd1, 2'd2, 1'b0);
        push(32'd404185, 8'd3, 2'd3, 1'b1);
        send(32'd1044, 8'd1, 1'b0);
        send(32'd34, 8'd2, 1'b0);
        send(32'd404185, 8'd3, 1'b0);
        send(32'd500, 8'd4, 1'b1);
        chk("first_out_valid", {63'd0, out_valid}, 64'd1);
        chk("drain_busy", {63'd0, busy}, 64'd1);
        chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
        wait_drain(1'b0);
        chk("post_drain_ready", {63'd0, in_ready}, 64'd1);

        // Overflow, ties, backpressure, ignored input during drain
        out_ready = 1'b0;
        push(32'd3, 8'd6, 2'd0, 1'b0);
        push(32'd5, 8'd4, 2'd1, 1'b0);
        push(32'd7, 8'd2, 2'd2, 1'b0);
        push(32'd7, 8'd3, 2'd3, 1'b1);
        send(32'd9, 8'd1, 1'b0);
        send(32'd7, 8'd2, 1'b0);
        send(32'd7, 8'd3, 1'b0);
        send(32'd5, 8'd4, 1'b0);
        send(32'd100, 8'd5, 1'b0);
        send(32'd3, 8'd6, 1'b1);
        chk("overflow_cnt", {48'd0, sample_cnt}, 64'd6);
        in_valid = 1'b1;
        in_dist  = 32'd1;
        in_label = 8'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_dist", {32'd0, out_dist}, 64'd3);
            chk("stall_label", {56'd0, out_label}, 64'd6);
            chk("stall_idx", {62'd0, out_idx}, 64'd0);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("stall_cnt", {48'd0, sample_cnt}, 64'd6);
        wait_drain(1'b1);
        chk("overflow_cnt_cleared", {48'd0, sample_cnt}, 64'd0);

        // Short query with the all-ones distance
        push(32'hFFFF_FFFF, 8'd9, 2'd0, 1'b1);
        send(32'hFFFF_FFFF, 8'd9, 1'b1);
        chk("short_last", {63'd0, out_last}, 64'd1);
        wait_drain(1'b0);
        chk("short_ready", {63'd0, in_ready}, 64'd1);

        // Clear in the middle of a drain
        out_ready = 1'b0;
        push(32'd10, 8'd1, 2'd0, 1'b0);
        push(32'd20, 8'd2, 2'd1, 1'b0);
        send(32'd10, 8'd1, 1'b0);
        send(32'd20, 8'd2, 1'b0);
        send(32'd30, 8'd3, 1'b0);
        send(32'd40, 8'd4, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_out_valid", {63'd0, out_valid}, 64'd0);
        chk("clear_busy", {63'd0, busy}, 64'd0);
        chk("clear_cnt", {48'd0, sample_cnt}, 64'd0);
        chk("clear_ready", {63'd0, in_ready}, 64'd1);
        chk("clear_idx", {62'd0, out_idx}, 64'd0);
        chk("clear_sb", 64'(sb.size()), 64'd0);
        in_valid = 1'b1;
        in_dist  = 32'd77;
        in_label = 8'd5;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_discard_cnt", {48'd0, sample_cnt}, 64'd0);
        out_ready = 1'b1;
        push(32'd50, 8'd7, 2'd0, 1'b0);
        push(32'd60, 8'd8, 2'd1, 1'b1);
        send(32'd50, 8'd7, 1'b0);
        send(32'd60, 8'd8, 1'b1);
        wait_drain(1'b0);

        // Asynchronous reset in the middle of a query
        send(32'd5, 8'd1, 1'b0);
        send(32'd6, 8'd2, 1'b0);
        chk("pre_rst_cnt", {48'd0, sample_cnt}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", {48'd0, sample_cnt}, 64'd0);
        chk("async_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_dist", {32'd0, out_dist}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(32'd8, 8'd1, 2'd0, 1'b1);
        send(32'd8, 8'd1, 1'b1);
        wait_drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/knn_kbest_sel.md
Name: knn_kbest_sel

Overview:
- Consumer end of the KNN distance stream: accepts (squared distance, label) pairs produced downstream of knn_core, one per cycle, via valid/ready.
- Maintains a sorted table of the K smallest distances seen in the current query.
- When the last sample of a query is accepted, streams the table out nearest-first over a second valid/ready interface, then clears for the next query.

Parameters:
- DATA_W, 32, distance width; matches knn_core z output.
- LABEL_W, 8, class label width carried with each distance.
- K, 4, table depth (number of neighbours kept); K >= 1.
- CNT_W, 16, width of the per-query accepted-sample counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; empties the table and returns to COLLECT.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_dist  in  DATA_W  squared distance, unsigned.
- in_label  in  LABEL_W  label of the training point.
- in_last  in  1  final sample of the query; qualified by in_valid.
- out_valid  out  1  table entry presented.
- out_ready  in  1  consumer takes the entry.
- out_dist  out  DATA_W  distance of the presented entry.
- out_label  out  LABEL_W  label of the presented entry.
- out_idx  out  clog2(K) (min 1)  rank; 0 = nearest.
- out_last  out  1  presented entry is the final one of the drain.
- busy  out  1  high in DRAIN.
- sample_cnt  out  CNT_W  samples accepted in the current query; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous):
  - state = COLLECT.
  - All slot valid bits = 0, slot dist/label = 0.
  - out_valid = 0, out_last = 0, out_idx = 0, out_dist = 0, out_label = 0.
  - busy = 0, sample_cnt = 0.
  - in_ready rises on the first posedge after rst goes high.
- States:
  - COLLECT: in_ready = 1, out_valid = 0.
  - DRAIN: in_ready = 0, busy = 1.
- Insertion (COLLECT, in_valid & in_ready):
  - Slot i takes the new entry when slot i is empty or in_dist < slot i dist (strict), and no lower slot took it.
  - Slots above the insertion point shift up one; slot K-1 is discarded.
  - Ties: the earlier sample keeps the lower rank (stable ordering).
  - A sample larger than all K valid entries is dropped, but sample_cnt still increments.
  - The table update is visible the next cycle; sustained throughput is 1 sample/cycle.
  - in_dist = all-ones is a legal value: it is inserted into an empty slot, because emptiness is tracked by the valid bit, not a sentinel.
- COLLECT -> DRAIN:
  - On an accepted sample with in_last = 1; that sample is inserted first.
  - DRAIN begins the next cycle with out_idx = 0 and out_valid = 1.
  - N = number of valid slots = min(accepted samples, K), always >= 1.
- DRAIN:
  - out_dist/out_label = slot[out_idx]; outputs are stable while out_valid & !out_ready.
  - out_last = (out_idx == N-1).
  - On out_valid & out_ready: out_idx increments.
  - On the handshake with out_last: next cycle returns to COLLECT, all valid bits cleared, sample_cnt = 0, out_valid = 0.
  - in_valid is ignored while in DRAIN; no sample is lost, since in_ready = 0.
- clear:
  - Takes priority over every other event in the same cycle.
  - Next cycle: COLLECT, table empty, sample_cnt = 0, out_valid = 0.
  - A sample presented in the same cycle as clear is discarded.
- Latency: accepted last sample -> first out_valid = 1 cycle. Drain of N entries takes N cycles with out_ready held high.

Decomposition:
- Shared header knn_kbest.vh:
  - state encodings KB_COLLECT, KB_DRAIN;
  - entry packing (valid, dist, label) and its width macro, reused by downstream vote logic.
- Sub-module knn_kbest_cell: one table slot.
  - Inputs: new entry, lower-neighbour entry, lower-slot "taken" flag.
  - Outputs: stored entry, own "taken" flag.
  - Instantiated K times in a generate chain.

Test Plan:
- Reset/idle: hold rst low 3 cycles, release -> in_ready = 1 next cycle; out_valid = 0; sample_cnt = 0; busy = 0.
- Ordering: feed 1044/L1, 34/L2, 404185/L3, 500/L4(last) back-to-back -> drain 34/L2, 500/L4, 1044/L1, 404185/L3; out_idx 0..3; out_last only on idx 3.
- Overflow and ties: K=4, feed 9,7,7,5,100,3(last) -> drain 3, 5, 7 (first-arrived 7), 7; sample_cnt = 6 before drain.
- Short query: single sample 0xFFFFFFFF/L9 with in_last -> one entry, idx 0, out_last = 1, then back to COLLECT.
- Backpressure: hold out_ready low 5 cycles in DRAIN -> outputs stable, in_ready = 0; random out_ready then yields correct order with no duplicates.
- Aborts:
  - Assert clear mid-DRAIN (after idx 1) -> next cycle COLLECT, table empty; a new 2-sample query drains only its own 2 entries.
  - Assert rst mid-COLLECT -> all outputs return to reset values immediately.
